// File: rtl/aes_spi_framer.sv
// rtl/aes_spi_framer.sv - SPI frame collector and launcher for an AES core
// Optional feature macro AES_SPI_KEY_CACHE_EN: accept plaintext-only frames that reuse the stored key.

module aes_spi_framer #(
  parameter int KEY_BITS    = 128,
  parameter int BLOCK_BITS  = 128,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_sck,
  input  logic                  i_sdi,
  output logic                  o_sdo,
  input  logic                  i_load,
  output logic                  o_done,
  output logic                  o_frame_err,
  output logic [KEY_BITS-1:0]   o_core_key,
  output logic [BLOCK_BITS-1:0] o_core_block,
  output logic                  o_core_start,
  input  logic                  i_core_done,
  input  logic [BLOCK_BITS-1:0] i_core_result
);

  localparam int FRAME_BITS = BLOCK_BITS + KEY_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FRAME    = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST_OUT = CNT_W'(BLOCK_BITS - 1);
`ifdef AES_SPI_KEY_CACHE_EN
  localparam logic [CNT_W-1:0] CNT_BLOCK    = CNT_W'(BLOCK_BITS);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_IN,
    S_START,
    S_WAIT_CORE,
    S_SHIFT_OUT
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_sdi_sync;
  logic [SYNC_STAGES-1:0] r_load_sync;
  logic                   r_sck_prev;
  logic                   r_load_prev;

  logic [CNT_W-1:0]       r_cnt;
  logic [FRAME_BITS-1:0]  r_frame;
  logic [BLOCK_BITS-1:0]  r_out;
  logic                   r_done;
  logic                   r_frame_err;
  logic [KEY_BITS-1:0]    r_core_key;
  logic [BLOCK_BITS-1:0]  r_core_block;
`ifdef AES_SPI_KEY_CACHE_EN
  logic                   r_key_valid;
`endif

  logic w_sck;
  logic w_sdi;
  logic w_load;
  logic w_sck_rise;
  logic w_sck_fall;
  logic w_load_rise;
  logic w_load_fall;

  logic w_clr_cnt;
  logic w_cnt_inc;
  logic w_shift_in;
  logic w_accept_full;
  logic w_accept_short;
  logic w_reject;
  logic w_capture;
  logic w_shift_out;
  logic w_end_out;
  logic w_abort;

  // sdi travels through the same depth as sck so it is aligned with the detected rise
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sck_sync  <= '0;
      r_sdi_sync  <= '0;
      r_load_sync <= '0;
      r_sck_prev  <= 1'b0;
      r_load_prev <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], i_sck};
      r_sdi_sync  <= {r_sdi_sync[SYNC_STAGES-2:0], i_sdi};
      r_load_sync <= {r_load_sync[SYNC_STAGES-2:0], i_load};
      r_sck_prev  <= w_sck;
      r_load_prev <= w_load;
    end
  end

  assign w_sck       = r_sck_sync[SYNC_STAGES-1];
  assign w_sdi       = r_sdi_sync[SYNC_STAGES-1];
  assign w_load      = r_load_sync[SYNC_STAGES-1];
  assign w_sck_rise  = w_sck & ~r_sck_prev;
  assign w_sck_fall  = ~w_sck & r_sck_prev;
  assign w_load_rise = w_load & ~r_load_prev;
  assign w_load_fall = ~w_load & r_load_prev;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_clr_cnt      = 1'b0;
    w_cnt_inc      = 1'b0;
    w_shift_in     = 1'b0;
    w_accept_full  = 1'b0;
    w_accept_short = 1'b0;
    w_reject       = 1'b0;
    w_capture      = 1'b0;
    w_shift_out    = 1'b0;
    w_end_out      = 1'b0;
    w_abort        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_load_rise) begin
          w_state_next = S_SHIFT_IN;
          w_clr_cnt    = 1'b1;
        end
      end
      S_SHIFT_IN: begin
        if (w_load_fall) begin
          if (r_cnt == CNT_FRAME) begin
            w_accept_full = 1'b1;
            w_state_next  = S_START;
`ifdef AES_SPI_KEY_CACHE_EN
          end else if ((r_cnt == CNT_BLOCK) && r_key_valid) begin
            w_accept_short = 1'b1;
            w_state_next   = S_START;
`endif
          end else begin
            w_reject     = 1'b1;
            w_state_next = S_IDLE;
          end
        end else if (w_sck_rise && (r_cnt != CNT_FRAME)) begin
          w_shift_in = 1'b1;
          w_cnt_inc  = 1'b1;
        end
      end
      S_START: begin
        w_state_next = S_WAIT_CORE;
      end
      S_WAIT_CORE: begin
        if (w_load_rise) begin
          w_abort      = 1'b1;
          w_clr_cnt    = 1'b1;
          w_state_next = S_SHIFT_IN;
        end else if (i_core_done) begin
          w_capture    = 1'b1;
          w_clr_cnt    = 1'b1;
          w_state_next = S_SHIFT_OUT;
        end
      end
      S_SHIFT_OUT: begin
        if (w_load_rise) begin
          w_abort      = 1'b1;
          w_clr_cnt    = 1'b1;
          w_state_next = S_SHIFT_IN;
        end else if (w_sck_fall) begin
          w_shift_out = 1'b1;
          w_cnt_inc   = 1'b1;
          if (r_cnt == CNT_LAST_OUT) begin
            w_end_out    = 1'b1;
            w_state_next = S_IDLE;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt        <= '0;
      r_frame      <= '0;
      r_out        <= '0;
      r_done       <= 1'b0;
      r_frame_err  <= 1'b0;
      r_core_key   <= '0;
      r_core_block <= '0;
`ifdef AES_SPI_KEY_CACHE_EN
      r_key_valid  <= 1'b0;
`endif
    end else begin
      r_frame_err <= w_reject;

      if (w_clr_cnt) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (w_shift_in) begin
        r_frame <= {r_frame[FRAME_BITS-2:0], w_sdi};
      end

      // Plaintext arrives first, so it ends up in the upper part of the frame
      if (w_accept_full) begin
        r_core_block <= r_frame[FRAME_BITS-1 -: BLOCK_BITS];
        r_core_key   <= r_frame[KEY_BITS-1:0];
`ifdef AES_SPI_KEY_CACHE_EN
        r_key_valid  <= 1'b1;
`endif
      end else if (w_accept_short) begin
        r_core_block <= r_frame[BLOCK_BITS-1:0];
      end

      if (w_capture) begin
        r_out <= i_core_result;
      end else if (w_abort) begin
        r_out <= '0;
      end else if (w_shift_out) begin
        r_out <= {r_out[BLOCK_BITS-2:0], 1'b0};
      end

      if (w_capture) begin
        r_done <= 1'b1;
      end else if (w_end_out || w_abort) begin
        r_done <= 1'b0;
      end
    end
  end

  assign o_sdo        = r_out[BLOCK_BITS-1];
  assign o_done       = r_done;
  assign o_frame_err  = r_frame_err;
  assign o_core_key   = r_core_key;
  assign o_core_block = r_core_block;
  assign o_core_start = (r_state == S_START);

endmodule

// File: tb/tb_aes_spi_framer.sv
// tb/tb_aes_spi_framer.sv - scoreboard bench for aes_spi_framer (128-bit and 256-bit key instances)
// Expected behaviour changes when AES_SPI_KEY_CACHE_EN is defined.

module tb_aes_spi_framer;

  localparam int HALF = 6;

  localparam logic [127:0] PT1  = 128'h3243F6A8885A308D313198A2E0370734;
  localparam logic [127:0] KEY1 = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
  localparam logic [127:0] CT1  = 128'h3925841D02DC09FBDC118597196A0B32;
  localparam logic [127:0] PT2  = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] KEY3 = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] CT2  = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
  localparam logic [127:0] PT3  = 128'hFFEEDDCCBBAA99887766554433221100;
  localparam logic [127:0] CT3  = 128'h8EA2B7CA516745BFEAFC49904B496089;
  localparam logic [255:0] KEY256 =
    256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;

  typedef struct {
    logic [127:0] block;
    logic [255:0] key;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, sck, sdi, load, load256;
  logic sdo, done, frame_err, core_start, core_done;
  logic [127:0] core_key, core_block, core_result, model_result;
  logic sdo2, done2, err2, start2, core_done2;
  logic [255:0] key2;
  logic [127:0] block2, core_result2;

  assign core_done2   = 1'b0;
  assign core_result2 = '0;

  int checks = 0;
  int errors = 0;

  exp_t         start_q[$];
  exp_t         start2_q[$];
  logic [127:0] err_q[$];
  logic [127:0] res_q[$];
  logic [127:0] rx_q[$];

  aes_spi_framer #(.KEY_BITS(128), .BLOCK_BITS(128), .SYNC_STAGES(2)) u_dut (
    .i_clk(clk), .i_reset(reset), .i_sck(sck), .i_sdi(sdi), .o_sdo(sdo),
    .i_load(load), .o_done(done), .o_frame_err(frame_err),
    .o_core_key(core_key), .o_core_block(core_block), .o_core_start(core_start),
    .i_core_done(core_done), .i_core_result(core_result)
  );

  aes_spi_framer #(.KEY_BITS(256), .BLOCK_BITS(128), .SYNC_STAGES(2)) u_dut256 (
    .i_clk(clk), .i_reset(reset), .i_sck(sck), .i_sdi(sdi), .o_sdo(sdo2),
    .i_load(load256), .o_done(done2), .o_frame_err(err2),
    .o_core_key(key2), .o_core_block(block2), .o_core_start(start2),
    .i_core_done(core_done2), .i_core_result(core_result2)
  );

  task automatic chk(input string name, input logic [383:0] got, input logic [383:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input bit use256, input bit raise, input logic [383:0] data,
                            input int nbits, input bit drop);
    if (raise) begin
      if (use256) load256 = 1'b1; else load = 1'b1;
      wait_clk(HALF);
    end
    for (int i = nbits - 1; i >= 0; i--) begin
      sdi = data[i];
      wait_clk(HALF);
      sck = 1'b1;
      wait_clk(HALF);
      sck = 1'b0;
    end
    if (drop) begin
      wait_clk(HALF);
      if (use256) load256 = 1'b0; else load = 1'b0;
      wait_clk(HALF);
    end
  endtask

  task automatic read_result(input int nbits);
    logic [127:0] val;
    int t;
    val = '0;
    t = 0;
    while (!done && t < 500) begin
      wait_clk(1);
      t++;
    end
    chk("done_rise_timeout", done, 1'b1);
    if (done) begin
      for (int i = 0; i < nbits; i++) begin
        wait_clk(HALF);
        sck = 1'b1;
        wait_clk(HALF);
        val = {val[126:0], sdo};
        sck = 1'b0;
      end
      if (nbits == 128) begin
        wait_clk(HALF);
        rx_q.push_back(val);
      end
    end
  endtask

  // Model AES core: answers every start with model_result after a short latency
  initial begin
    core_done   = 1'b0;
    core_result = '0;
    forever begin
      @(negedge clk);
      if (core_start) begin
        wait_clk(5);
        core_result = model_result;
        core_done   = 1'b1;
        wait_clk(1);
        core_done   = 1'b0;
      end
    end
  end

  initial begin
    exp_t e;
    logic [127:0] b;
    forever begin
      @(negedge clk);
      if (core_start) begin
        if (start_q.size() == 0) begin
          chk("core_start_unexpected", core_start, 1'b0);
        end else begin
          e = start_q.pop_front();
          chk("core_block", core_block, e.block);
          chk("core_key", core_key, e.key);
        end
      end
      if (frame_err) begin
        if (err_q.size() == 0) begin
          chk("frame_err_unexpected", frame_err, 1'b0);
        end else begin
          b = err_q.pop_front();
          chk("frame_err_block_held", core_block, b);
          chk("frame_err_no_start", core_start, 1'b0);
        end
      end
      if (start2) begin
        if (start2_q.size() == 0) begin
          chk("core_start256_unexpected", start2, 1'b0);
        end else begin
          e = start2_q.pop_front();
          chk("core_block256", block2, e.block);
          chk("core_key256", key2, e.key);
        end
      end
      if (err2) chk("frame_err256_unexpected", err2, 1'b0);
      if (rx_q.size() > 0) begin
        b = rx_q.pop_front();
        if (res_q.size() == 0) chk("readback_no_expect", 32'(res_q.size()), 32'd1);
        else chk("readback", b, res_q.pop_front());
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; sck = 1'b0; sdi = 1'b0; load = 1'b0; load256 = 1'b0;
    model_result = '0;
    wait_clk(3);
    chk("rst_sdo", sdo, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_core_start", core_start, 1'b0);
    chk("rst_core_key", core_key, 128'h0);
    chk("rst_core_block", core_block, 128'h0);
    reset = 1'b0;
    wait_clk(4);

    // 256-bit key instance
    start2_q.push_back('{PT2, KEY256});
    send_frame(1'b1, 1'b1, {PT2, KEY256}, 384, 1'b1);
    wait_clk(10);

    // Known-answer frame and full read-back
    model_result = CT1;
    start_q.push_back('{PT1, {128'h0, KEY1}});
    res_q.push_back(CT1);
    send_frame(1'b0, 1'b1, {128'h0, PT1, KEY1}, 256, 1'b1);
    read_result(128);
    chk("done_after_readback", done, 1'b0);

    // Sck activity while idle must be ignored
    for (int i = 0; i < 3; i++) begin
      wait_clk(HALF); sck = 1'b1; wait_clk(HALF); sck = 1'b0;
    end

    // One bit short of a full frame
    err_q.push_back(PT1);
    send_frame(1'b0, 1'b1, {128'h0, PT2, KEY3}, 255, 1'b1);
    wait_clk(10);
    chk("short255_done", done, 1'b0);
    chk("short255_key_held", core_key, KEY1);

    // Plaintext-only frame
`ifdef AES_SPI_KEY_CACHE_EN
    model_result = CT2;
    start_q.push_back('{PT2, {128'h0, KEY1}});
    res_q.push_back(CT2);
    send_frame(1'b0, 1'b1, {256'h0, PT2}, 128, 1'b1);
    read_result(128);
`else
    err_q.push_back(PT1);
    send_frame(1'b0, 1'b1, {256'h0, PT2}, 128, 1'b1);
    wait_clk(10);
`endif

    // Reset in the middle of a frame (after 100 bits)
    send_frame(1'b0, 1'b1, ({128'h0, PT3, KEY3} >> 156), 100, 1'b0);
    reset = 1'b1;
    load  = 1'b0;
    wait_clk(1);
    chk("midrst_sdo", sdo, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_frame_err", frame_err, 1'b0);
    chk("midrst_core_start", core_start, 1'b0);
    chk("midrst_core_key", core_key, 128'h0);
    chk("midrst_core_block", core_block, 128'h0);
    reset = 1'b0;
    wait_clk(4);

`ifdef AES_SPI_KEY_CACHE_EN
    err_q.push_back(128'h0);
    send_frame(1'b0, 1'b1, {256'h0, PT2}, 128, 1'b1);
    wait_clk(10);
`endif

    // Full frame, abort during read-back after 40 bits, then a new frame
    model_result = CT2;
    start_q.push_back('{PT2, {128'h0, KEY3}});
    send_frame(1'b0, 1'b1, {128'h0, PT2, KEY3}, 256, 1'b1);
    read_result(40);
    chk("done_before_abort", done, 1'b1);
    load = 1'b1;
    wait_clk(4);
    chk("abort_done", done, 1'b0);
    model_result = CT3;
    start_q.push_back('{PT3, {128'h0, KEY1}});
    res_q.push_back(CT3);
    send_frame(1'b0, 1'b0, {128'h0, PT3, KEY1}, 256, 1'b1);
    read_result(128);
    chk("done_after_abort_frame", done, 1'b0);

    wait_clk(20);
    chk("start_q_drained", 32'(start_q.size()), 32'd0);
    chk("start256_q_drained", 32'(start2_q.size()), 32'd0);
    chk("err_q_drained", 32'(err_q.size()), 32'd0);
    chk("res_q_drained", 32'(res_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_spi_framer.md
AES_SPI_FRAMER -- requirements
Module: aes_spi_framer

Interface
REQ-001 Parameter KEY_BITS, default 128, key length in bits; legal values 128, 192, 256.
REQ-002 Parameter BLOCK_BITS, default 128, plaintext and cyphertext length in bits.
REQ-003 Parameter SYNC_STAGES, default 2, number of synchroniser flops on sck, sdi and load; minimum 2.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 sck  input  1  SPI clock from the host; asynchronous to clk.
REQ-007 sdi  input  1  SPI data in, MSB first.
REQ-008 sdo  output  1  SPI data out, MSB first.
REQ-009 load  input  1  host frame strobe; high while shifting in.
REQ-010 done  output  1  result ready; high until the result is fully shifted out or the frame is aborted.
REQ-011 frame_err  output  1  one-cycle pulse on a rejected frame.
REQ-012 core_key  output  KEY_BITS  key presented to the AES core.
REQ-013 core_block  output  BLOCK_BITS  plaintext presented to the AES core.
REQ-014 core_start  output  1  one-cycle start pulse to the core.
REQ-015 core_done  input  1  core result valid; sampled only in WAIT_CORE.
REQ-016 core_result  input  BLOCK_BITS  cyphertext from the core.

Function
REQ-017 sck, sdi and load each pass through SYNC_STAGES flops; sck edges are detected from the last two synchronised samples; the host holds sck high and low for at least SYNC_STAGES+2 clk cycles each.
REQ-018 States: IDLE, SHIFT_IN, START, WAIT_CORE, SHIFT_OUT.
REQ-019 IDLE -> SHIFT_IN on a synchronised load rise; the bit counter clears to 0 on entry.
REQ-020 SHIFT_IN: on each sck rise, shift sdi into a FRAME_BITS = BLOCK_BITS+KEY_BITS register (plaintext first, then key) and increment the counter; the counter saturates at FRAME_BITS, and further bits are ignored.
REQ-021 On a synchronised load fall with count == FRAME_BITS, latch core_block and core_key and go to START; otherwise pulse frame_err and go to IDLE.
REQ-022 START lasts exactly one cycle with core_start = 1, then goes to WAIT_CORE.
REQ-023 WAIT_CORE: on core_done = 1, capture core_result into the output shift register, assert done, drive sdo = result MSB on the next cycle, and go to SHIFT_OUT.
REQ-024 SHIFT_OUT: on each sck fall, shift left so sdo presents the next bit; after BLOCK_BITS falls, deassert done and go to IDLE.
REQ-025 A load rise in SHIFT_OUT or WAIT_CORE aborts: done deasserts and the state goes to SHIFT_IN with the counter cleared; a late core_done is ignored.
REQ-026 sck edges in IDLE and START are ignored.
REQ-027 core_key and core_block hold their values until the next accepted frame.

Reset
REQ-028 With reset = 1 at a clk edge: state = IDLE, counter = 0, sdo = 0, done = 0, frame_err = 0, core_start = 0, core_key = 0, core_block = 0, synchronisers cleared, key-valid flag cleared.
REQ-029 Reset has priority over every other event, including mid-frame and mid-WAIT_CORE.

Configuration
REQ-030 Macro AES_SPI_KEY_CACHE_EN: when defined, a frame with count == BLOCK_BITS at load fall is accepted if the key-valid flag is set; it updates core_block only and reuses the stored core_key. A short frame with the flag clear pulses frame_err. The flag sets on any accepted full frame.
REQ-031 When AES_SPI_KEY_CACHE_EN is undefined, only full FRAME_BITS frames are accepted, and no key-valid flag exists.

Verification
REQ-032 KEY_BITS=128: shift 3243F6A8885A308D313198A2E0370734 then 2B7E151628AED2A6ABF7158809CF4F3C -> one core_start pulse with matching core_block/core_key; model core returns 3925841D02DC09FBDC118597196A0B32 -> 128 sck falls read back exactly that value, then done = 0.
REQ-033 Frame with 255 bits, load falls -> frame_err pulses once, no core_start, state IDLE.
REQ-034 KEY_BITS=256: shift 00112233445566778899AABBCCDDEEFF then 000102...1F -> core_key = 000102...1F, core_start pulses once.
REQ-035 reset asserted at bit 100 of a frame -> all outputs 0 next cycle; a subsequent full frame succeeds.
REQ-036 load rise during SHIFT_OUT after 40 bits -> done = 0 within SYNC_STAGES+2 cycles; the new frame is accepted normally.
REQ-037 AES_SPI_KEY_CACHE_EN: full frame, then a 128-bit frame 00112233445566778899AABBCCDDEEFF -> core_key unchanged, core_block updated; after reset, the same short frame -> frame_err.
